// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 asynchronous serial receiver, LSB first.
// The RX line is double-synchronised, the start bit is qualified at mid-bit,
// and every data/stop bit is sampled once, in the middle of its bit period.
// Good frames produce a one-cycle oValid with oData updated in that same cycle;
// frames whose stop bit samples low produce a one-cycle oFrameErr instead.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iRx,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrameErr,
    output logic       oBusy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Terminal counts: half a bit to reach mid-start, a full bit for the rest.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser; reset to the idle (high) line level.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= iRx;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: bit timing, mid-bit sampling and frame checking.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // A line that is high again at mid-start was only a glitch.
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    // Right shift so the first (LSB) bit ends in shift_q[0].
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Hold off until the line recovers so a break gives one error.
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign oData     = data_q;
    assign oValid    = valid_q;
    assign oFrameErr = ferr_q;
    assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler at 16 clocks per bit. A reference model predicts
// the outputs from the recorded RX waveform using sample-point arithmetic
// relative to the detected start edge; every cycle is compared against it.
// Directed frames plus randomized traffic; literal checks pin the model.
module tb_uart_rx_sampler;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic       iClk   = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iRx    = 1'b1;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oBusy;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(16)
    ) dut (
        .iClk(iClk),
        .iRst_n(iRst_n),
        .iRx(iRx),
        .oData(oData),
        .oValid(oValid),
        .oFrameErr(oFrameErr),
        .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int         cyc        = 0;     // number of the most recent rising edge
    bit         rx_hist [0:65535];  // iRx as sampled at each edge
    int         last_rst   = -10;
    int         mode       = 0;     // 0 idle, 1 in frame, 2 waiting for line high
    int         start_edge = 0;
    int         m_off;
    int         m_j;
    logic [7:0] mbyte      = 8'h00;
    logic [7:0] exp_data   = 8'h00;
    logic       exp_valid  = 1'b0;
    logic       exp_ferr   = 1'b0;
    logic       exp_busy   = 1'b0;
    bit         model_live = 1'b0;

    // Synchronised line level seen by the receiver at edge n (two edges late,
    // and forced high for the two edges following a reset).
    function automatic bit rxs(input int n);
        if (n < 2 || (n - 2) <= last_rst) return 1'b1;
        return rx_hist[n - 2];
    endfunction

    always @(posedge iClk) begin
        cyc = cyc + 1;
        rx_hist[cyc] = iRx;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (!iRst_n) begin
            last_rst = cyc;
            mode     = 0;
            exp_data = 8'h00;
        end else begin
            case (mode)
                0: begin
                    if (!rxs(cyc)) begin
                        mode       = 1;
                        start_edge = cyc;
                    end
                end
                1: begin
                    m_off = cyc - start_edge;
                    if (m_off == H) begin
                        if (rxs(cyc)) mode = 0;
                    end else if (m_off > H && ((m_off - H) % CPB) == 0) begin
                        m_j = (m_off - H) / CPB;
                        if (m_j <= 8) begin
                            mbyte[m_j - 1] = rxs(cyc);
                        end else if (rxs(cyc)) begin
                            exp_data  = mbyte;
                            exp_valid = 1'b1;
                            mode      = 0;
                        end else begin
                            exp_ferr = 1'b1;
                            mode     = 2;
                        end
                    end
                end
                default: begin
                    if (rxs(cyc)) mode = 0;
                end
            endcase
        end
        exp_busy   = (mode != 0);
        model_live = 1'b1;
    end

    // ---------------- per-cycle compare and monitor ----------------
    logic [7:0] got_q [$];
    int         ferr_cnt       = 0;
    int         last_valid_cyc = -1;

    always @(negedge iClk) begin
        if (model_live) begin
            vectors++;
            if ({oValid, oFrameErr, oBusy, oData} !== {exp_valid, exp_ferr, exp_busy, exp_data}) begin
                miscompares++;
                $display("FAIL outputs @%0d: got valid=%b ferr=%b busy=%b data=%02h, want valid=%b ferr=%b busy=%b data=%02h",
                         cyc, oValid, oFrameErr, oBusy, oData, exp_valid, exp_ferr, exp_busy, exp_data);
            end
            if (oValid === 1'b1) begin
                got_q.push_back(oData);
                last_valid_cyc = cyc;
                $display("cycle %0d: byte 0x%02h received", cyc, oData);
            end
            if (oFrameErr === 1'b1) begin
                ferr_cnt++;
                $display("cycle %0d: framing error", cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, want, want);
        end
    endtask

    task automatic drive(input logic v, input int n);
        iRx = v;
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    function automatic int last_byte();
        if (got_q.size() == 0) return -1;
        return int'(got_q[got_q.size() - 1]);
    endfunction

    int drive_edge;
    int n_before;
    int f_before;

    initial begin
        // Reset and idle line.
        iRst_n = 1'b0;
        iRx    = 1'b1;
        repeat (3) begin
            @(posedge iClk);
            #1;
        end
        check("reset oData", int'(oData), 0);
        check("reset oBusy", int'(oBusy), 0);
        check("reset strobes", int'({oValid, oFrameErr}), 0);
        iRst_n = 1'b1;
        drive(1'b1, 200);
        check("idle no bytes", got_q.size(), 0);
        check("idle no errors", ferr_cnt, 0);

        // Single byte and its latency from the start edge.
        drive_edge = cyc;
        send(8'hA5, 1'b1);
        drive(1'b1, 20);
        check("A5 count", got_q.size(), 1);
        check("A5 value", last_byte(), 8'hA5);
        check("A5 latency", last_valid_cyc - drive_edge, 155);

        // Back-to-back frames.
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        drive(1'b1, 20);
        check("b2b count", got_q.size(), 4);
        check("b2b first", int'(got_q[1]), 8'h00);
        check("b2b second", int'(got_q[2]), 8'hFF);
        check("b2b third", int'(got_q[3]), 8'h3C);
        check("b2b no errors", ferr_cnt, 0);

        // Framing error followed by a break.
        send(8'h55, 1'b0);
        drive(1'b0, 100);
        check("break busy", int'(oBusy), 1);
        drive(1'b1, 20);
        check("break one error", ferr_cnt, 1);
        check("break data held", int'(oData), 8'h3C);
        check("break no byte", got_q.size(), 4);
        send(8'h12, 1'b1);
        drive(1'b1, 20);
        check("after break", last_byte(), 8'h12);

        // Short glitch rejected at mid-start.
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("glitch no byte", got_q.size(), 5);
        check("glitch no error", ferr_cnt, 1);
        send(8'h81, 1'b1);
        drive(1'b1, 20);
        check("after glitch", last_byte(), 8'h81);

        // Reset in the middle of data bit 3 of 0xF0.
        n_before = got_q.size();
        drive(1'b0, CPB);
        drive(1'b0, 3 * CPB);
        drive(1'b0, H);
        iRst_n = 1'b0;
        iRx    = 1'b1;
        repeat (3) begin
            @(posedge iClk);
            #1;
        end
        iRst_n = 1'b1;
        drive(1'b1, 30);
        check("abort no byte", got_q.size(), n_before);
        check("abort data reset", int'(oData), 0);
        send(8'h0F, 1'b1);
        drive(1'b1, 20);
        check("after abort", last_byte(), 8'h0F);

        // Randomized traffic: good frames, bad stop bits, glitches, gaps.
        for (int k = 0; k < 60; k++) begin
            int kind;
            logic [7:0] b;
            kind = int'($urandom_range(0, 9));
            b    = 8'($urandom);
            n_before = got_q.size();
            f_before = ferr_cnt;
            if (kind == 0) begin
                send(b, 1'b0);
                drive(1'b0, int'($urandom_range(0, 40)));
                drive(1'b1, 2 * CPB);
                check("rand ferr", ferr_cnt - f_before, 1);
            end else if (kind == 1) begin
                drive(1'b0, int'($urandom_range(1, H - 2)));
                drive(1'b1, 2 * CPB);
                check("rand glitch", got_q.size() - n_before, 0);
            end else begin
                send(b, 1'b1);
                drive(1'b1, int'($urandom_range(0, 12)));
            end
        end
        drive(1'b1, 3 * CPB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
